add_seq_ctrl: RTL and testbench

//   Multi-precision add/subtract sequencer. Reuses one 8-bit ripple adder to

---
 rtl/add_seq_ctrl_pkg.sv | 17 +
 rtl/add_seq_ctrl_if.sv | 30 +++
 rtl/add_seq_ctrl_byte_adder.sv | 26 ++
 rtl/add_seq_ctrl.sv | 118 +++++++++++
 tb/tb_add_seq_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/add_seq_ctrl_pkg.sv
// Shared definitions for the byte-serial add/subtract sequencer.
package add_seq_ctrl_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Byte index counter width; at least one bit even for a single-byte build.
    function automatic int unsigned idx_width(input int unsigned nbytes);
        return (nbytes <= 1) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// Request/result handshake bundle for add_seq_ctrl.
interface add_seq_ctrl_if #(
    parameter int unsigned NBYTES = 4
);
    import add_seq_ctrl_pkg::*;

    localparam int unsigned WIDTH = BYTE_W * NBYTES;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/add_seq_ctrl_byte_adder.sv
// Purely combinational 8-bit ripple-carry adder shared by every byte step.
module byte_adder
    import add_seq_ctrl_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] s,
    output logic              cout
);

    logic [BYTE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < int'(BYTE_W); i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[BYTE_W];

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one byte per cycle, LSB first,
// carry chained through a register, valid/ready on both sides.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int unsigned NBYTES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    add_seq_ctrl_if.slave bus
);

    localparam int unsigned       IDX_W    = idx_width(NBYTES);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NBYTES - 1);

    state_e                         state_q, state_n;
    logic [IDX_W-1:0]               idx_q, idx_n;
    logic                           carry_q, carry_n;
    logic [NBYTES-1:0][BYTE_W-1:0]  a_q, a_n;
    logic [NBYTES-1:0][BYTE_W-1:0]  b_q, b_n;
    logic [NBYTES-1:0][BYTE_W-1:0]  sum_q, sum_n;
    logic                           cout_q, cout_n;
    logic                           ovf_q, ovf_n;
    logic                           in_ready_q, in_ready_n;
    logic                           out_valid_q, out_valid_n;

    logic [BYTE_W-1:0]              add_s;
    logic                           add_co;

    byte_adder u_adder (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .s    (add_s),
        .cout (add_co)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            idx_q       <= idx_n;
            carry_q     <= carry_n;
            a_q         <= a_n;
            b_q         <= b_n;
            sum_q       <= sum_n;
            cout_q      <= cout_n;
            ovf_q       <= ovf_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        carry_n = carry_q;
        a_n     = a_q;
        b_n     = b_q;
        sum_n   = sum_q;
        cout_n  = cout_q;
        ovf_n   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    // Subtraction is A + ~B + 1, the +1 entering as initial carry.
                    a_n     = bus.a;
                    b_n     = bus.sub ? ~bus.b : bus.b;
                    carry_n = bus.sub;
                    idx_n   = '0;
                    sum_n   = '0;
                    state_n = ST_RUN;
                end
            end
            ST_RUN: begin
                sum_n[idx_q] = add_s;
                carry_n      = add_co;
                if (idx_q == IDX_LAST) begin
                    cout_n  = add_co;
                    ovf_n   = (a_q[NBYTES-1][BYTE_W-1] == b_q[NBYTES-1][BYTE_W-1]) &&
                              (add_s[BYTE_W-1] != a_q[NBYTES-1][BYTE_W-1]);
                    state_n = ST_DONE;
                end else begin
                    idx_n = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        in_ready_n  = (state_n == ST_IDLE);
        out_valid_n = (state_n == ST_DONE);
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl: directed corner cases plus random ops
// against an arithmetic reference, on a 4-byte and a 1-byte instance.
module tb_add_seq_ctrl;

    localparam int unsigned NB = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;

    add_seq_ctrl_if #(.NBYTES(NB)) bus ();
    add_seq_ctrl_if #(.NBYTES(1))  bus1 ();

    add_seq_ctrl #(.NBYTES(NB)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    add_seq_ctrl #(.NBYTES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference result {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [33:0] model32(input logic [31:0] x, input logic [31:0] y, input logic s);
        logic [32:0] full;
        logic        o;
        if (!s) begin
            full = {1'b0, x} + {1'b0, y};
            o    = (x[31] == y[31]) && (full[31] != x[31]);
        end else begin
            full = {1'b0, x} + {1'b0, ~y} + 33'd1;
            o    = (x[31] != y[31]) && (full[31] != x[31]);
        end
        return {o, full};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
        logic [8:0] full;
        logic       o;
        if (!s) begin
            full = {1'b0, x} + {1'b0, y};
            o    = (x[7] == y[7]) && (full[7] != x[7]);
        end else begin
            full = {1'b0, x} + {1'b0, ~y} + 9'd1;
            o    = (x[7] != y[7]) && (full[7] != x[7]);
        end
        return {o, full};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", 64'(bus.in_ready), 64'd1);
    endtask

    // One full transaction on the 4-byte instance with `hold` cycles of backpressure.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts, input int hold);
        logic [33:0] exp;
        logic [31:0] held;
        int          n;
        exp = model32(ta, tb_v, ts);
        wait_ready();
        bus.a = ta; bus.b = tb_v; bus.sub = ts; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom);
        chk("busy_in_ready", 64'(bus.in_ready), 64'd0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(NB));
        chk("sum", 64'(bus.sum), 64'(exp[31:0]));
        chk("cout", 64'(bus.cout), 64'(exp[32]));
        chk("ovf", 64'(bus.ovf), 64'(exp[33]));
        held = bus.sum;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'(i % 2);
            @(posedge clk); #1;
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_sum", 64'(bus.sum), 64'(exp[31:0]));
            chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
        end
        // in_valid stays high across the output handshake; it must not be taken.
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b0;
        chk("post_valid", 64'(bus.out_valid), 64'd0);
        chk("post_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_sum", 64'(bus.sum), 64'(held));
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [7:0]  xa, xb;
        logic        xs;
        logic [9:0]  e8;
        int          n;

        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0; bus1.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_sum", 64'(bus.sum), 64'd0);
        chk("rst_cout", 64'(bus.cout), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 0);
        do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
        do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1);
        do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 0);
        do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 2);
        do_op(32'h1234_5678, 32'h0000_0000, 1'b1, 10);

        // Abort mid-operation, while the third byte is being processed.
        wait_ready();
        bus.a = 32'hAAAA_AAAA; bus.b = 32'h1111_1111; bus.sub = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_sum", 64'(bus.sum), 64'd0);
        chk("abort_valid", 64'(bus.out_valid), 64'd0);
        chk("abort_cout", 64'(bus.cout), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
        do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            case ($urandom_range(0, 4))
                0: ra = 32'h0000_0000;
                1: ra = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0: rb = 32'h7FFF_FFFF;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'h0000_0001;
                default: rb = $urandom;
            endcase
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Single-byte instance: 0x80+0x80, then random ops.
        for (int k = 0; k < 8; k++) begin
            if (k == 0) begin
                xa = 8'h80; xb = 8'h80; xs = 1'b0;
            end else begin
                xa = 8'($urandom); xb = 8'($urandom); xs = 1'($urandom);
            end
            e8 = model8(xa, xb, xs);
            n = 0;
            while (!bus1.in_ready && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("b1_in_ready", 64'(bus1.in_ready), 64'd1);
            bus1.a = xa; bus1.b = xb; bus1.sub = xs; bus1.in_valid = 1'b1;
            @(posedge clk); #1;
            bus1.in_valid = 1'b0;
            n = 0;
            while (!bus1.out_valid && n < 10) begin
                @(posedge clk); #1;
                n++;
            end
            chk("b1_latency", 64'(n), 64'd1);
            chk("b1_sum", 64'(bus1.sum), 64'(e8[7:0]));
            chk("b1_cout", 64'(bus1.cout), 64'(e8[8]));
            chk("b1_ovf", 64'(bus1.ovf), 64'(e8[9]));
            bus1.out_ready = 1'b1;
            @(posedge clk); #1;
            bus1.out_ready = 1'b0;
            chk("b1_post_valid", 64'(bus1.out_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
